// File: rtl/irq_vector_ctrl_if.sv
// Bus bundle between the mc6809 side (CPU register access, bus status,
// peripheral requests) and the prioritised interrupt vector controller.
interface irq_vector_ctrl_if #(
    parameter int NUM_SRC = 8
);
    logic               CS;
    logic [1:0]         RS;
    logic               RnW;
    logic [7:0]         DIN;
    logic [7:0]         DOUT;
    logic               BS;
    logic               BA;
    logic [NUM_SRC-1:0] SRC;
    logic               nIRQ;
    logic [15:0]        Intvector;

    // Controller side
    modport slave (
        input  CS, RS, RnW, DIN, BS, BA, SRC,
        output DOUT, nIRQ, Intvector
    );

    // CPU / peripheral side
    modport master (
        output CS, RS, RnW, DIN, BS, BA, SRC,
        input  DOUT, nIRQ, Intvector
    );
endinterface

// File: rtl/irq_vector_ctrl.sv
// Prioritised interrupt controller feeding the mc6809 nIRQ and Intvector
// inputs. Requests are synchronised, latched per source as level or edge,
// masked by EN and arbitrated lowest-index-first. The vector is frozen for
// the whole interrupt-acknowledge window (BS=1, BA=0); entering the window
// retires the acknowledged edge source.
module irq_vector_ctrl #(
    parameter int          NUM_SRC  = 8,
    parameter logic [15:0] VEC_BASE = 16'hFF00
) (
    input  logic              CLK,
    input  logic              RESET,
    irq_vector_ctrl_if.slave  bus
);

    // Vector handed out when nothing is pending and enabled.
    localparam logic [15:0] VEC_SPUR = VEC_BASE + 16'(2 * NUM_SRC);
    localparam logic [3:0]  IDX_NONE = 4'(NUM_SRC);

    logic [NUM_SRC-1:0] sync1_q;
    logic [NUM_SRC-1:0] sync_q;      // synchronised request S
    logic [NUM_SRC-1:0] sdly_q;      // S delayed one cycle
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] en_q,   en_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [3:0]         act_q,  act_d;
    logic [15:0]        vec_q,  vec_d;
    logic               nirq_q, nirq_d;
    logic               ackw_q;

    logic               ackw;
    logic               ack_entry;
    logic               wr_en;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] sw_clr;
    logic [NUM_SRC-1:0] ack_clr;
    logic [3:0]         win;
    logic [7:0]         dout;

    assign ackw      = bus.BS & ~bus.BA;
    assign ack_entry = ackw & ~ackw_q;
    assign wr_en     = bus.CS & ~bus.RnW;
    assign req       = pend_q & en_q;
    assign edge_set  = sync_q & ~sdly_q;

    // Zero-extend a per-source register to the 8-bit data bus.
    function automatic logic [7:0] widen(input logic [NUM_SRC-1:0] v);
        logic [7:0] r;
        r = '0;
        r[NUM_SRC-1:0] = v;
        return r;
    endfunction

    // Priority pick: lowest enabled pending index wins, NUM_SRC if none.
    always_comb begin
        win = IDX_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) win = 4'(i);
        end
    end

    // Next-state for pending/enable/mode, request output and vector tracking.
    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        sw_clr = '0;
        if (wr_en) begin
            case (bus.RS)
                2'd0:    sw_clr = bus.DIN[NUM_SRC-1:0];
                2'd1:    en_d   = bus.DIN[NUM_SRC-1:0];
                2'd2:    mode_d = bus.DIN[NUM_SRC-1:0];
                default: ;
            endcase
        end

        // Only the source latched in ACT at window entry is retired, and
        // only if it is edge-triggered.
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = ack_entry & (act_q == 4'(i)) & mode_q[i];
        end

        // Level sources mirror S; edge sources let a new edge beat any clear.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mode_q[i])
                pend_d[i] = edge_set[i] | (pend_q[i] & ~(sw_clr[i] | ack_clr[i]));
            else
                pend_d[i] = sync_q[i];
        end

        nirq_d = ~|req;

        // Hold the vector from the cycle before entry for the whole window.
        if (ackw) begin
            act_d = act_q;
            vec_d = vec_q;
        end else begin
            act_d = win;
            vec_d = VEC_BASE + {11'b0, win, 1'b0};
        end
    end

    // Two-flop request synchroniser plus edge history.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync_q  <= '0;
            sdly_q  <= '0;
        end else begin
            sync1_q <= bus.SRC;
            sync_q  <= sync1_q;
            sdly_q  <= sync_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_q <= '0;
            en_q   <= '0;
            mode_q <= '0;
            act_q  <= IDX_NONE;
            vec_q  <= VEC_SPUR;
            nirq_q <= 1'b1;
            ackw_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            en_q   <= en_d;
            mode_q <= mode_d;
            act_q  <= act_d;
            vec_q  <= vec_d;
            nirq_q <= nirq_d;
            ackw_q <= ackw;
        end
    end

    // Combinational register read mux; idle bus reads as zero.
    always_comb begin
        dout = 8'h00;
        if (bus.CS && bus.RnW) begin
            case (bus.RS)
                2'd0:    dout = widen(pend_q);
                2'd1:    dout = widen(en_q);
                2'd2:    dout = widen(mode_q);
                default: dout = {4'b0, act_q};
            endcase
        end
    end

    assign bus.DOUT      = dout;
    assign bus.nIRQ      = nirq_q;
    assign bus.Intvector = vec_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Scoreboard bench for irq_vector_ctrl: expected values are queued when the
// stimulus is applied and popped when the corresponding DUT output is sampled.
module tb_irq_vector_ctrl;

    logic CLK = 1'b0;
    logic RESET;

    irq_vector_ctrl_if #(.NUM_SRC(8)) bus ();

    irq_vector_ctrl #(.NUM_SRC(8), .VEC_BASE(16'hFF00)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [15:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL sb_empty: got %h expected <none>", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] rs, input logic [7:0] d);
        bus.CS  = 1'b1;
        bus.RnW = 1'b0;
        bus.RS  = rs;
        bus.DIN = d;
        cyc(1);
        bus.CS  = 1'b0;
        bus.RnW = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [1:0] rs, input logic [7:0] exp);
        push(tag, {8'h00, exp});
        bus.CS  = 1'b1;
        bus.RnW = 1'b1;
        bus.RS  = rs;
        #1;
        pop_cmp({8'h00, bus.DOUT});
        bus.CS  = 1'b0;
    endtask

    task automatic outs(input string tag, input logic nirq, input logic [15:0] vec);
        push({tag, ".nIRQ"}, {15'b0, nirq});
        push({tag, ".vec"}, vec);
        pop_cmp({15'b0, bus.nIRQ});
        pop_cmp(bus.Intvector);
    endtask

    initial begin
        RESET     = 1'b1;
        bus.CS    = 1'b0;
        bus.RS    = 2'd0;
        bus.RnW   = 1'b1;
        bus.DIN   = 8'h00;
        bus.BS    = 1'b0;
        bus.BA    = 1'b0;
        bus.SRC   = 8'h00;

        // 1: reset state
        cyc(2);
        RESET = 1'b0;
        cyc(1);
        rd("rst_pend", 2'd0, 8'h00);
        rd("rst_en",   2'd1, 8'h00);
        rd("rst_mode", 2'd2, 8'h00);
        rd("rst_act",  2'd3, 8'h08);
        outs("rst", 1'b1, 16'hFF10);

        // 2: level source latency, assert and release
        wr(2'd1, 8'hFF);
        bus.SRC = 8'h08;
        cyc(3);
        outs("lvl_early", 1'b1, 16'hFF10);
        cyc(1);
        outs("lvl_on", 1'b0, 16'hFF06);
        rd("lvl_pend", 2'd0, 8'h08);
        bus.SRC = 8'h00;
        cyc(3);
        outs("lvl_hold", 1'b0, 16'hFF06);
        cyc(1);
        outs("lvl_off", 1'b1, 16'hFF10);

        // 3: edge sources, priority and acknowledge retire
        wr(2'd2, 8'hFF);
        bus.SRC = 8'h20; cyc(1); bus.SRC = 8'h00; cyc(2);
        bus.SRC = 8'h04; cyc(1); bus.SRC = 8'h00; cyc(5);
        rd("edg_pend", 2'd0, 8'h24);
        outs("edg_win", 1'b0, 16'hFF04);
        bus.BS = 1'b1;
        cyc(1);
        rd("ack_act",  2'd3, 8'h02);
        rd("ack_pend", 2'd0, 8'h20);
        outs("ack_frz", 1'b0, 16'hFF04);
        cyc(1);
        outs("ack_frz2", 1'b0, 16'hFF04);
        bus.BS = 1'b0;
        cyc(1);
        outs("ack_exit", 1'b0, 16'hFF0A);
        rd("exit_act", 2'd3, 8'h05);

        // 4: new edge collides with its own acknowledge clear
        bus.SRC = 8'h04; cyc(1); bus.SRC = 8'h00; cyc(5);
        outs("col_pre", 1'b0, 16'hFF04);
        bus.SRC = 8'h04;
        cyc(2);
        bus.BS = 1'b1;
        cyc(1);
        rd("col_pend", 2'd0, 8'h24);
        outs("col_frz", 1'b0, 16'hFF04);
        bus.BS  = 1'b0;
        bus.SRC = 8'h00;
        cyc(2);
        rd("col_after", 2'd0, 8'h24);

        // 5: software clear against simultaneous edge, level ignores clear
        bus.SRC = 8'h01;
        cyc(2);
        wr(2'd0, 8'hFF);
        rd("swclr_pend", 2'd0, 8'h01);
        wr(2'd2, 8'hFE);
        rd("mode_rd", 2'd2, 8'hFE);
        cyc(1);
        wr(2'd0, 8'h01);
        rd("lvl_noclr", 2'd0, 8'h01);
        wr(2'd3, 8'hAA);
        rd("act_ro", 2'd3, 8'h00);
        bus.SRC = 8'h00;
        cyc(3);
        rd("lvl_drop", 2'd0, 8'h00);

        // 6: masked requests, spurious acknowledge, reset mid-window
        wr(2'd2, 8'h00);
        bus.SRC = 8'hFF;
        wr(2'd1, 8'h00);
        cyc(4);
        rd("msk_pend", 2'd0, 8'hFF);
        outs("msk", 1'b1, 16'hFF10);
        wr(2'd2, 8'hFF);
        cyc(1);
        bus.BS = 1'b1;
        cyc(2);
        rd("spur_pend", 2'd0, 8'hFF);
        rd("spur_act",  2'd3, 8'h08);
        outs("spur", 1'b1, 16'hFF10);
        bus.BS = 1'b0;
        wr(2'd1, 8'hFF);
        cyc(1);
        outs("en_all", 1'b0, 16'hFF00);
        bus.BS = 1'b1;
        cyc(1);
        rd("ack0_pend", 2'd0, 8'hFE);
        outs("ack0_frz", 1'b0, 16'hFF00);
        RESET = 1'b1;
        #1;
        outs("mid_rst", 1'b1, 16'hFF10);
        rd("mid_rst_pend", 2'd0, 8'h00);
        rd("mid_rst_en",   2'd1, 8'h00);
        rd("mid_rst_mode", 2'd2, 8'h00);
        rd("mid_rst_act",  2'd3, 8'h08);
        bus.SRC = 8'h00;
        bus.BS  = 1'b0;
        cyc(1);
        RESET = 1'b0;
        cyc(2);
        outs("post_rst", 1'b1, 16'hFF10);

        if (sb.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
